// File: rtl/ddr3_refresh_scheduler.sv
`timescale 1ns/1ps
// DDR3 auto-refresh scheduler: tREFI ticks, owed-refresh bookkeeping and PRECHARGE ALL / REFRESH
// ownership of the command bus. Define REF_BURST_EN to chain owed REFRESHes behind one precharge.
module ddr3_refresh_scheduler #(
    parameter int TREFI_CYC    = 4875,
    parameter int TRP_CYC      = 10,
    parameter int TRFC_CYC     = 70,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 13
) (
    input  logic        clk,
    input  logic        resetbar,
    input  logic        ready,
    input  logic        ck,
    input  logic        cmd_req,
    input  logic        cmd_busy,
    output logic        cmd_grant,
    output logic        ref_active,
    output logic        csbar,
    output logic        rasbar,
    output logic        casbar,
    output logic        webar,
    output logic [2:0]  ba,
    output logic [12:0] a,
    output logic [3:0]  pending_cnt,
    output logic        ref_overflow
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DRAIN     = 3'd1,
        PRE       = 3'd2,
        TRP_WAIT  = 3'd3,
        REF       = 3'd4,
        TRFC_WAIT = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] REFI_LAST = CNT_W'(TREFI_CYC - 1);
    localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'(TRP_CYC - 1);
    localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'(TRFC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [3:0]       PEND_URG  = 4'(MAX_POSTPONE);
    localparam logic [3:0]       PEND_SAT  = 4'(MAX_POSTPONE + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] refi_cnt;
    logic [CNT_W-1:0] tcnt;
    logic             tick;
    logic             guard;
    logic             urgent;
    logic             start_ref;
    logic             pre_launch;
    logic             ref_launch;
    logic             trp_done;
    logic             trfc_done;
    logic             burst_more;

    assign tick      = ready && (refi_cnt == REFI_LAST);
    assign urgent    = (pending_cnt >= PEND_URG);
    assign start_ref = ready && (pending_cnt != 4'd0) && (urgent || !cmd_req);
    assign trp_done  = (tcnt >= TRP_LAST);
    assign trfc_done = (tcnt >= TRFC_LAST);

`ifdef REF_BURST_EN
    assign burst_more = (pending_cnt != 4'd0);
`else
    assign burst_more = 1'b0;
`endif

    // tREFI interval timer; keeps running while a refresh sequence is in flight
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            refi_cnt <= '0;
        end else if (!ready || tick) begin
            refi_cnt <= '0;
        end else begin
            refi_cnt <= refi_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            pending_cnt  <= 4'd0;
            ref_overflow <= 1'b0;
        end else if (!ready) begin
            pending_cnt  <= 4'd0;
        end else begin
            if (tick && (pending_cnt == PEND_SAT)) begin
                ref_overflow <= 1'b1;
            end
            if (tick && !ref_launch && (pending_cnt != PEND_SAT)) begin
                pending_cnt <= pending_cnt + 4'd1;
            end else if (ref_launch && !tick) begin
                pending_cnt <= pending_cnt - 4'd1;
            end
        end
    end

    // guard covers the cycle between a grant and cmd_busy rising
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            guard <= 1'b0;
        end else begin
            guard <= cmd_grant;
        end
    end

    // tRP / tRFC counter restarts on every launch
    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            tcnt <= '0;
        end else if (pre_launch || ref_launch) begin
            tcnt <= '0;
        end else if (tcnt != CNT_MAX) begin
            tcnt <= tcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetbar) begin
        if (!resetbar) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Launches only happen on ck=1 edges so each 2-cycle command straddles a ck rising edge
    always_comb begin
        state_next = state;
        pre_launch = 1'b0;
        ref_launch = 1'b0;
        if (!ready) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ref) state_next = DRAIN;
                end
                DRAIN: begin
                    if (!cmd_busy && !guard && ck) begin
                        state_next = PRE;
                        pre_launch = 1'b1;
                    end
                end
                PRE: begin
                    if (tcnt != '0) state_next = TRP_WAIT;
                end
                TRP_WAIT: begin
                    if (trp_done && ck) begin
                        state_next = REF;
                        ref_launch = 1'b1;
                    end
                end
                REF: begin
                    if (tcnt != '0) state_next = TRFC_WAIT;
                end
                TRFC_WAIT: begin
                    if (trfc_done) begin
                        if (burst_more) begin
                            if (ck) begin
                                state_next = REF;
                                ref_launch = 1'b1;
                            end
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_grant  = ready && cmd_req && (state == IDLE) && !cmd_busy && !guard && !start_ref;
        ref_active = (state == PRE) || (state == TRP_WAIT) || (state == REF) || (state == TRFC_WAIT);
        csbar      = 1'b1;
        rasbar     = 1'b1;
        casbar     = 1'b1;
        webar      = 1'b1;
        ba         = 3'd0;
        a          = 13'd0;
        case (state)
            PRE: begin
                csbar  = 1'b0;
                rasbar = 1'b0;
                webar  = 1'b0;
                a[10]  = 1'b1;
            end
            REF: begin
                csbar  = 1'b0;
                rasbar = 1'b0;
                casbar = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr3_refresh_scheduler.sv
`timescale 1ns/1ps
// Directed bench for ddr3_refresh_scheduler with short timing parameters.
module tb_ddr3_refresh_scheduler;

    localparam logic [3:0] C_NOP = 4'b1111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;

    logic        clk = 1'b0;
    logic        ck = 1'b0;
    logic        resetbar = 1'b0;
    logic        ready = 1'b0;
    logic        cmd_req = 1'b0;
    logic        cmd_busy = 1'b0;
    logic        cmd_grant;
    logic        ref_active;
    logic        csbar, rasbar, casbar, webar;
    logic [2:0]  ba;
    logic [12:0] a;
    logic [3:0]  pending_cnt;
    logic        ref_overflow;
    logic [3:0]  cmd;

    int checks = 0;
    int failures = 0;
    int busy_left = 0;
    int viol = 0;
    int bad_rise = 0;
    int rises = 0;
    int grants_p1 = 0;
    int grants_after = 0;
    logic fall_seen = 1'b0;

    assign cmd = {csbar, rasbar, casbar, webar};

    ddr3_refresh_scheduler #(
        .TREFI_CYC(50), .TRP_CYC(4), .TRFC_CYC(8), .MAX_POSTPONE(2), .CNT_W(13)
    ) dut (
        .clk(clk), .resetbar(resetbar), .ready(ready), .ck(ck),
        .cmd_req(cmd_req), .cmd_busy(cmd_busy), .cmd_grant(cmd_grant),
        .ref_active(ref_active), .csbar(csbar), .rasbar(rasbar), .casbar(casbar),
        .webar(webar), .ba(ba), .a(a), .pending_cnt(pending_cnt), .ref_overflow(ref_overflow)
    );

    always #5 clk = ~clk;
    always #10 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clock with a processing-logic model that stays busy 3 cycles per grant
    task automatic step_proc();
        logic g, ra0, b0;
        logic [3:0] p0;
        @(negedge clk);
        cmd_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        #1;
        g = cmd_grant; ra0 = ref_active; p0 = pending_cnt; b0 = cmd_busy;
        if (g) busy_left = 3;
        if (g && (ra0 || b0 || p0 >= 4'd2)) viol++;
        if (g && p0 == 4'd1 && !fall_seen) grants_p1++;
        if (g && fall_seen) grants_after++;
        @(posedge clk);
        #1;
        if (ref_active && !ra0) begin
            rises++;
            if (p0 < 4'd2 || b0) bad_rise++;
        end
        if (!ref_active && ra0) fall_seen = 1'b1;
    endtask

    initial begin
        int n;
        int bad;
        logic ck_ref;

        // Reset state
        #2;
        check("rst_cmd", cmd, C_NOP);
        check("rst_a", a, 0);
        check("rst_ba", ba, 0);
        check("rst_ref_active", ref_active, 0);
        check("rst_grant", cmd_grant, 0);
        check("rst_pending", pending_cnt, 0);
        check("rst_overflow", ref_overflow, 0);
        cyc(3);
        resetbar = 1'b1;
        cyc(2);

        // 1: single refresh with no host traffic
        ready = 1'b1;
        cyc(49);
        check("t1_no_early_tick", pending_cnt, 0);
        cyc(1);
        check("t1_tick", pending_cnt, 1);
        ck_ref = ck;
        n = 0;
        while (!ref_active && n < 6) begin cyc(1); n++; end
        check("t1_pre_latency", n, ck_ref ? 2 : 3);
        check("t1_pre_ck", ck, 1);
        check("t1_pre_cmd", cmd, C_PRE);
        check("t1_pre_a10", a, 13'h400);
        check("t1_pre_ba", ba, 0);
        cyc(1);
        check("t1_pre_hold", cmd, C_PRE);
        cyc(1);
        check("t1_trp_nop", cmd, C_NOP);
        check("t1_trp_active", ref_active, 1);
        cyc(2);
        check("t1_ref_cmd", cmd, C_REF);
        check("t1_ref_a", a, 0);
        check("t1_ref_pending", pending_cnt, 0);
        cyc(1);
        check("t1_ref_hold", cmd, C_REF);
        cyc(6);
        check("t1_trfc_active", ref_active, 1);
        check("t1_trfc_nop", cmd, C_NOP);
        cyc(1);
        check("t1_release", ref_active, 0);

        // 2: host traffic postpones refresh until urgent
        cmd_req = 1'b1;
        for (int i = 0; i < 160; i++) step_proc();
        check("t2_refresh_ran", rises >= 1, 1);
        check("t2_grant_violations", viol, 0);
        check("t2_bad_refresh_start", bad_rise, 0);
        check("t2_grants_while_postponed", grants_p1 > 0, 1);
        check("t2_grants_resume", grants_after > 0, 1);

        // 3/6: urgent refresh beats a simultaneous request, then the REF sequence
        cmd_req = 1'b0;
        cmd_busy = 1'b0;
        n = 0;
        while ((pending_cnt != 4'd0 || ref_active) && n < 100) begin cyc(1); n++; end
        check("t3_drained", n < 100, 1);
        cmd_req = 1'b1;
        cmd_busy = 1'b1;
        n = 0;
        while (pending_cnt != 4'd2 && n < 120) begin cyc(1); n++; end
        check("t3_reach_urgent", pending_cnt, 2);
        cmd_busy = 1'b0;
        #1;
        check("t3_grant_blocked", cmd_grant, 0);
        check("t3_idle", ref_active, 0);
        cyc(1);
        check("t3_drain_no_grant", cmd_grant, 0);
        ck_ref = ck;
        n = 0;
        while (!ref_active && n < 6) begin cyc(1); n++; end
        check("t3_pre_latency", n, ck_ref ? 2 : 1);
        check("t3_pre_cmd", cmd, C_PRE);
        cyc(4);
        check("t6_ref1_cmd", cmd, C_REF);
        check("t6_ref1_pending", pending_cnt, 1);
        cyc(8);
`ifdef REF_BURST_EN
        check("t6_ref2_cmd", cmd, C_REF);
        check("t6_ref2_active", ref_active, 1);
        check("t6_ref2_pending", pending_cnt, 0);
        cyc(8);
        check("t6_burst_release", ref_active, 0);
`else
        check("t6_single_release", ref_active, 0);
        check("t6_single_nop", cmd, C_NOP);
        check("t6_single_pending", pending_cnt, 1);
        check("t6_grant_resumes", cmd_grant, 1);
`endif

        // 4: saturation and sticky overflow with the bus held busy
        resetbar = 1'b0;
        cmd_req = 1'b1;
        cmd_busy = 1'b1;
        #1;
        check("t4_reset_pending", pending_cnt, 0);
        cyc(1);
        resetbar = 1'b1;
        cyc(49);
        check("t4_p0", pending_cnt, 0);
        cyc(1);
        check("t4_p1", pending_cnt, 1);
        cyc(50);
        check("t4_p2", pending_cnt, 2);
        check("t4_p2_no_grant", cmd_grant, 0);
        cyc(50);
        check("t4_p3", pending_cnt, 3);
        cyc(49);
        check("t4_no_overflow_yet", ref_overflow, 0);
        cyc(1);
        check("t4_overflow", ref_overflow, 1);
        check("t4_saturated", pending_cnt, 3);
        cyc(20);
        check("t4_overflow_sticky", ref_overflow, 1);
        check("t4_stuck_in_drain", ref_active, 0);
        cmd_busy = 1'b0;
        cmd_req = 1'b0;
        n = 0;
        while (cmd != C_REF && n < 12) begin cyc(1); n++; end
        check("t4_ref_issued", cmd, C_REF);
        check("t4_ref_pending", pending_cnt, 2);
        check("t4_overflow_after_ref", ref_overflow, 1);

        // 5: asynchronous reset in the middle of REF
        #2;
        resetbar = 1'b0;
        #1;
        check("t5_cmd_nop", cmd, C_NOP);
        check("t5_inactive", ref_active, 0);
        check("t5_pending", pending_cnt, 0);
        check("t5_overflow", ref_overflow, 0);
        cyc(1);
        resetbar = 1'b1;
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            cyc(1);
            if (cmd != C_NOP || ref_active) bad++;
        end
        check("t5_quiet_until_tick", bad, 0);
        check("t5_pending_before_tick", pending_cnt, 0);
        cyc(1);
        check("t5_tick", pending_cnt, 1);
        n = 0;
        while (!ref_active && n < 6) begin cyc(1); n++; end
        check("t5_pre_cmd", cmd, C_PRE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
